// File: rtl/async_fifo.sv
// rtl/async_fifo.sv - single-clock circular FIFO with Gray-coded pointer flags and error pulses
// Optional macro FIFO_LEVEL_EN adds the 'level' occupancy output.
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active-high
//   wr_en      write request, accepted when not full
//   wdata      write data
//   rd_en      read request, accepted when not empty
//   rdata      registered read data, valid after the accepting edge
//   full       FIFO holds DEPTH entries
//   empty      FIFO holds 0 entries
//   overflow   one-cycle pulse after an edge with wr_en=1 while full
//   underflow  one-cycle pulse after an edge with rd_en=1 while empty
//   level      (FIFO_LEVEL_EN only) entries held, 0..DEPTH
module async_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rdata,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 underflow
`ifdef FIFO_LEVEL_EN
  ,
  output logic [PTR_WIDTH:0]   level
`endif
);

  localparam logic [PTR_WIDTH:0] PTR_ONE  = {{PTR_WIDTH{1'b0}}, 1'b1};
  // Selects the Gray bits below the top two; zero when PTR_WIDTH is 1.
  localparam logic [PTR_WIDTH:0] LOW_MASK = (PTR_ONE << (PTR_WIDTH - 1)) - PTR_ONE;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_WIDTH:0] wr_bin, rd_bin;
  logic [PTR_WIDTH:0] wr_gray, rd_gray;
  logic [PTR_WIDTH:0] wr_bin_next, rd_bin_next;
  logic               wr_acc, rd_acc;

  always_comb begin
    empty       = (wr_gray == rd_gray);
    // Full: top two Gray bits inverted, remaining bits equal.
    full        = (wr_gray[PTR_WIDTH:PTR_WIDTH-1] == ~rd_gray[PTR_WIDTH:PTR_WIDTH-1]) &&
                  (((wr_gray ^ rd_gray) & LOW_MASK) == '0);
    wr_acc      = wr_en && !full;
    rd_acc      = rd_en && !empty;
    wr_bin_next = wr_bin + PTR_ONE;
    rd_bin_next = rd_bin + PTR_ONE;
  end

  // Storage is never cleared; a reset only moves the pointers.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_bin[PTR_WIDTH-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bin    <= '0;
      rd_bin    <= '0;
      wr_gray   <= '0;
      rd_gray   <= '0;
      rdata     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_acc) begin
        wr_bin  <= wr_bin_next;
        wr_gray <= wr_bin_next ^ (wr_bin_next >> 1);
      end
      if (rd_acc) begin
        rdata   <= mem[rd_bin[PTR_WIDTH-1:0]];
        rd_bin  <= rd_bin_next;
        rd_gray <= rd_bin_next ^ (rd_bin_next >> 1);
      end
    end
  end

`ifdef FIFO_LEVEL_EN
  assign level = wr_bin - rd_bin;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// tb/tb_async_fifo.sv - self-checking bench for async_fifo against a queue reference model
module tb_async_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rdata;
  logic       full, empty, overflow, underflow;
`ifdef FIFO_LEVEL_EN
  logic [3:0] level;
`endif

  async_fifo #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
`ifdef FIFO_LEVEL_EN
    , .level(level)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: contents as a queue, plus expected registered outputs.
  logic [7:0] q[$];
  logic [7:0] m_rdata;
  bit         m_ovf, m_unf;

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete(); m_rdata = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  // Drive one cycle and advance the model using the pre-edge occupancy.
  task automatic cycle(input bit w, input logic [7:0] d, input bit r);
    bit pre_full, pre_empty;
    wr_en = w; wdata = d; rd_en = r;
    pre_full  = (q.size() == 8);
    pre_empty = (q.size() == 0);
    m_ovf = w && pre_full;
    m_unf = r && pre_empty;
    if (r && !pre_empty) m_rdata = q.pop_front();
    if (w && !pre_full) q.push_back(d);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
`ifdef FIFO_LEVEL_EN
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
`endif
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'($urandom), 1'b0);
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty edge=%0d got=%b exp=0", i+1, empty); end
      checks++; if (full !== (i == 7)) begin errors++; $display("FAIL fill_full edge=%0d got=%b exp=%b", i+1, full, (i == 7)); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow edge=%0d got=%b exp=0", i+1, overflow); end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_pulse edge=%0d got=%b exp=1", i+1, underflow); end
      checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL unf_rdata edge=%0d got=%h exp=00", i+1, rdata); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL unf_empty edge=%0d got=%b exp=1", i+1, empty); end
    end
  endtask

  task automatic test_overflow_drain();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      cycle(1'b1, 8'($urandom), 1'b0);
      checks++; if (overflow !== (i >= 8)) begin errors++; $display("FAIL ovf_pulse edge=%0d got=%b exp=%b", i+1, overflow, (i >= 8)); end
      checks++; if (full !== (i >= 7)) begin errors++; $display("FAIL ovf_full edge=%0d got=%b exp=%b", i+1, full, (i >= 7)); end
`ifdef FIFO_LEVEL_EN
      checks++; if (level !== 4'(q.size())) begin errors++; $display("FAIL ovf_level edge=%0d got=%0d exp=%0d", i+1, level, q.size()); end
`endif
    end
    for (int i = 0; i < 13; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL drain_rdata edge=%0d got=%h exp=%h", i+1, rdata, m_rdata); end
      checks++; if (underflow !== (i >= 8)) begin errors++; $display("FAIL drain_unf edge=%0d got=%b exp=%b", i+1, underflow, (i >= 8)); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty_end got=%b exp=1", empty); end
  endtask

  task automatic test_random();
    int wl, rl, n_op;
    bit do_w, do_r;
    do_reset();
    wl = 19; rl = 15; n_op = 0;
    // Extra corner ops: simultaneous on empty at start, on full and again on empty at the end.
    while (n_op < 38) begin
      do_w = 1'b0; do_r = 1'b0;
      if (n_op == 0) begin
        do_w = 1'b1; do_r = 1'b1;
      end else if (n_op < 35) begin
        if (rl > 0 && q.size() > 0 && (wl == 0 || q.size() == 8 || $urandom_range(1) == 1)) do_r = 1'b1;
        else if (wl > 0) do_w = 1'b1;
        if (do_r) rl--;
        if (do_w) wl--;
      end else if (n_op == 35) begin
        while (q.size() < 8) cycle(1'b1, 8'($urandom), 1'b0);
        do_w = 1'b1; do_r = 1'b1;
      end else if (n_op == 36) begin
        while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1);
        do_w = 1'b1; do_r = 1'b1;
      end else begin
        do_r = 1'b1;
      end
      cycle(do_w, 8'($urandom), do_r);
      checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata op=%0d got=%h exp=%h", n_op, rdata, m_rdata); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow op=%0d got=%b exp=%b", n_op, overflow, m_ovf); end
      checks++; if (underflow !== m_unf) begin errors++; $display("FAIL rnd_underflow op=%0d got=%b exp=%b", n_op, underflow, m_unf); end
      checks++; if (full !== (q.size() == 8)) begin errors++; $display("FAIL rnd_full op=%0d got=%b exp=%b", n_op, full, (q.size() == 8)); end
      checks++; if (empty !== (q.size() == 0)) begin errors++; $display("FAIL rnd_empty op=%0d got=%b exp=%b", n_op, empty, (q.size() == 0)); end
`ifdef FIFO_LEVEL_EN
      checks++; if (level !== 4'(q.size())) begin errors++; $display("FAIL rnd_level op=%0d got=%0d exp=%0d", n_op, level, q.size()); end
`endif
      for (int k = $urandom_range(5); k > 0; k--) begin
        cycle(1'b0, 8'h00, 1'b0);
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL rnd_idle_pulse op=%0d got=%b%b exp=00", n_op, overflow, underflow); end
      end
      n_op++;
      if (n_op == 35) begin
        checks++; if (q.size() != 5 || empty !== 1'b0) begin errors++; $display("FAIL rnd_mid_count got=%0d/%b exp=5/0", q.size(), empty); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0);
    do_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL mid_rst_full got=%b exp=0", full); end
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL mid_rst_rdata got=%h exp=a5", rdata); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty_end got=%b exp=1", empty); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_underflow();
    test_overflow_drain();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
